// File: rtl/board_scan_pkg.sv
// Shared types and sizing helpers for the board matrix scanner.
package board_scan_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, EVAL} scan_state_t;

    // Bits needed to hold a count of 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_tick_div.sv
// Row dwell timer: counts 0..TICK_DIV-1 and flags the last cycle of each row.
module scan_tick_div
    import board_scan_pkg::*;
#(
    parameter int TICK_DIV = 300000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/board_scan_debounce.sv
// Row-strobed switch matrix scanner that commits the occupancy word only after
// DEB_FRAMES identical frames and flags real changes until acknowledged.
module board_scan_debounce
    import board_scan_pkg::*;
#(
    parameter int ROWS            = 8,
    parameter int COLS            = 8,
    parameter int TICK_DIV        = 300000,
    parameter int DEB_FRAMES      = 3,
    parameter int ROW_ACTIVE_HIGH = 1,
    parameter int COL_ACTIVE_HIGH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [COLS-1:0]      col_in,
    input  logic                 ack,
    output logic [ROWS-1:0]      row_out,
    output logic [ROWS*COLS-1:0] layout,
    output logic                 layout_valid,
    output logic                 changed,
    output logic                 frame_done
);

    localparam int RW = cnt_width(ROWS);
    localparam int SW = cnt_width(DEB_FRAMES + 1);
    localparam logic [ROWS-1:0] ROW_IDLE = (ROW_ACTIVE_HIGH != 0) ? '0 : '1;
    localparam logic [COLS-1:0] COL_INV  = (COL_ACTIVE_HIGH != 0) ? '0 : '1;

    scan_state_t               state;
    logic [RW-1:0]             row_idx;
    logic [ROWS-1:0][COLS-1:0] raw;
    logic [ROWS-1:0][COLS-1:0] prev;
    logic [SW-1:0]             stable_cnt;
    logic [SW-1:0]             stable_next;
    logic                      commit;
    logic                      tick;

    function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] idx);
        logic [ROWS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return (ROW_ACTIVE_HIGH != 0) ? oh : ~oh;
    endfunction

    scan_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state != SCAN),
        .tick (tick)
    );

    // Saturating run length of identical frames, including the one just finished.
    always_comb begin
        stable_next = SW'(1);
        if (raw == prev) begin
            stable_next = (stable_cnt >= SW'(DEB_FRAMES)) ? SW'(DEB_FRAMES) : stable_cnt + SW'(1);
        end
    end

    assign commit = (stable_next == SW'(DEB_FRAMES));

    // row_out is loaded with the strobe for the state being entered so it stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            row_idx      <= '0;
            raw          <= '0;
            prev         <= '0;
            stable_cnt   <= '0;
            layout       <= '0;
            layout_valid <= 1'b0;
            changed      <= 1'b0;
            frame_done   <= 1'b0;
            row_out      <= ROW_IDLE;
        end else begin
            frame_done <= 1'b0;
            if (ack) begin
                changed <= 1'b0;
            end
            case (state)
                IDLE: begin
                    row_out <= ROW_IDLE;
                    if (enable) begin
                        state   <= SCAN;
                        row_idx <= '0;
                        row_out <= row_drive('0);
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        row_out <= ROW_IDLE;
                    end else if (tick) begin
                        raw[row_idx] <= col_in ^ COL_INV;
                        if (row_idx == RW'(ROWS - 1)) begin
                            state   <= EVAL;
                            row_out <= ROW_IDLE;
                        end else begin
                            row_idx <= row_idx + RW'(1);
                            row_out <= row_drive(row_idx + RW'(1));
                        end
                    end
                end
                EVAL: begin
                    if (!enable) begin
                        state   <= IDLE;
                        row_out <= ROW_IDLE;
                    end else begin
                        stable_cnt <= stable_next;
                        prev       <= raw;
                        if (commit) begin
                            layout       <= raw;
                            layout_valid <= 1'b1;
                            if ((raw != layout) || !layout_valid) begin
                                changed <= 1'b1;
                            end
                        end
                        frame_done <= 1'b1;
                        state      <= SCAN;
                        row_idx    <= '0;
                        row_out    <= row_drive('0);
                    end
                end
                default: begin
                    state   <= IDLE;
                    row_out <= ROW_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_scan_debounce.sv
// Self-checking bench: a frame-level reference model of the scanner is compared
// against the DUT every cycle, plus directed literal checks of the key scenarios.
module tb_board_scan_debounce;

    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int TICK_DIV   = 4;
    localparam int DEB_FRAMES = 3;
    localparam int FRAME      = ROWS * TICK_DIV;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      enable;
    logic                      ack;
    logic [COLS-1:0]           col_in;
    logic [ROWS-1:0]           row_out;
    logic [ROWS*COLS-1:0]      layout;
    logic                      layout_valid;
    logic                      changed;
    logic                      frame_done;
    logic [ROWS-1:0][COLS-1:0] board;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    board_scan_debounce #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .TICK_DIV       (TICK_DIV),
        .DEB_FRAMES     (DEB_FRAMES),
        .ROW_ACTIVE_HIGH(1),
        .COL_ACTIVE_HIGH(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .col_in      (col_in),
        .ack         (ack),
        .row_out     (row_out),
        .layout      (layout),
        .layout_valid(layout_valid),
        .changed     (changed),
        .frame_done  (frame_done)
    );

    // Physical matrix: a column reads high when any strobed row has a piece on it.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_out[r]) begin
                col_in = col_in | board[r];
            end
        end
    end

    // Reference model: position within the frame plus a history of completed frames.
    bit          m_active;
    int          m_pos;
    logic [63:0] m_raw;
    logic [63:0] m_hist[$];
    logic [63:0] m_layout;
    bit          m_valid;
    bit          m_changed;
    bit          m_fd;

    task automatic frameEnd();
        bit same;
        m_hist.push_back(m_raw);
        if (m_hist.size() > DEB_FRAMES) begin
            void'(m_hist.pop_front());
        end
        same = (m_hist.size() == DEB_FRAMES);
        foreach (m_hist[i]) begin
            if (m_hist[i] != m_raw) same = 1'b0;
        end
        if (same) begin
            if (!m_valid || m_layout != m_raw) m_changed = 1'b1;
            m_layout = m_raw;
            m_valid  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_active  = 1'b0;
            m_pos     = 0;
            m_raw     = '0;
            m_hist.delete();
            m_layout  = '0;
            m_valid   = 1'b0;
            m_changed = 1'b0;
            m_fd      = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (ack) m_changed = 1'b0;
            if (!m_active) begin
                if (enable) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (!enable) begin
                m_active = 1'b0;
            end else if (m_pos < FRAME) begin
                if (m_pos % TICK_DIV == TICK_DIV - 1) begin
                    m_raw[(m_pos / TICK_DIV) * COLS +: COLS] = board[m_pos / TICK_DIV];
                end
                m_pos++;
            end else begin
                frameEnd();
                m_fd  = 1'b1;
                m_pos = 0;
            end
        end
    end

    function automatic logic [63:0] expRow();
        logic [ROWS-1:0] one;
        one = ROWS'(1);
        if (m_active && m_pos < FRAME) return 64'(one << (m_pos / TICK_DIV));
        return 64'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("row_out", 64'(row_out), expRow());
            checkOutput("frame_done", 64'(frame_done), 64'(m_fd));
            checkOutput("layout", layout, m_layout);
            checkOutput("layout_valid", 64'(layout_valid), 64'(m_valid));
            checkOutput("changed", 64'(changed), 64'(m_changed));
        end
    end

    task automatic applyStimulus(input bit rst, input bit en, input bit ak, input int cycles);
        reset  = rst;
        enable = en;
        ack    = ak;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitFrameDone(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_done && cycles < 200);
        if (!frame_done) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_done_timeout: got none within %0d cycles expected a pulse", cycles);
        end
    endtask

    initial begin
        int gap;
        int fd_seen;
        int off;

        board  = '0;
        reset  = 1'b1;
        enable = 1'b1;
        ack    = 1'b0;
        @(negedge clk);
        applyStimulus(1, 1, 0, 2);
        check_en = 1'b1;

        checkOutput("reset_row_out", 64'(row_out), 64'h0);
        checkOutput("reset_layout", layout, 64'h0);
        checkOutput("reset_valid", 64'(layout_valid), 64'h0);
        checkOutput("reset_changed", 64'(changed), 64'h0);
        checkOutput("reset_frame_done", 64'(frame_done), 64'h0);

        $display("[TB] static piece at (2,5)");
        board[2][5] = 1'b1;
        applyStimulus(0, 1, 0, 0);
        waitFrameDone(gap);
        waitFrameDone(gap);
        checkOutput("frame_period_2", 64'(gap), 64'd33);
        waitFrameDone(gap);
        checkOutput("frame_period_3", 64'(gap), 64'd33);
        checkOutput("static_layout", layout, 64'h0000_0000_0020_0000);
        checkOutput("static_model", m_layout, 64'h0000_0000_0020_0000);
        checkOutput("static_valid", 64'(layout_valid), 64'h1);
        checkOutput("static_changed", 64'(changed), 64'h1);

        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("ack_clears", 64'(changed), 64'h0);

        $display("[TB] one-frame glitch at (0,0)");
        waitFrameDone(gap);
        board[0][0] = 1'b1;
        waitFrameDone(gap);
        board[0][0] = 1'b0;
        repeat (4) waitFrameDone(gap);
        checkOutput("glitch_layout", layout, 64'h0000_0000_0020_0000);
        checkOutput("glitch_changed", 64'(changed), 64'h0);

        $display("[TB] ack racing a committing frame");
        waitFrameDone(gap);
        board[7][7] = 1'b1;
        waitFrameDone(gap);
        waitFrameDone(gap);
        applyStimulus(0, 1, 0, 32);
        applyStimulus(0, 1, 1, 1);
        ack = 1'b0;
        checkOutput("race_frame_done", 64'(frame_done), 64'h1);
        checkOutput("race_layout", layout, 64'h8000_0000_0020_0000);
        checkOutput("race_changed", 64'(changed), 64'h1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("late_ack_clears", 64'(changed), 64'h0);

        $display("[TB] enable drop during row 4");
        waitFrameDone(gap);
        applyStimulus(0, 1, 0, 17);
        checkOutput("row4_strobe", 64'(row_out), 64'h10);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drop_row_out", 64'(row_out), 64'h0);
        fd_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) fd_seen++;
        end
        checkOutput("drop_no_frame_done", 64'(fd_seen), 64'd0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("restart_row_out", 64'(row_out), 64'h01);
        checkOutput("drop_layout_held", layout, 64'h8000_0000_0020_0000);

        $display("[TB] randomized traffic");
        off = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                board[$urandom_range(0, ROWS - 1)][$urandom_range(0, COLS - 1)] ^= 1'b1;
            end
            if (off > 0) begin
                off--;
            end else if ($urandom_range(0, 299) == 0) begin
                off = $urandom_range(1, 40);
            end
            applyStimulus(0, (off == 0), ($urandom_range(0, 24) == 0), 1);
        end

        $display("[TB] reset mid-scan after a valid commit");
        applyStimulus(0, 1, 0, 0);
        repeat (4) waitFrameDone(gap);
        checkOutput("pre_reset_valid", 64'(layout_valid), 64'h1);
        applyStimulus(0, 1, 0, 10);
        applyStimulus(1, 1, 0, 1);
        checkOutput("midreset_layout", layout, 64'h0);
        checkOutput("midreset_valid", 64'(layout_valid), 64'h0);
        checkOutput("midreset_changed", 64'(changed), 64'h0);
        checkOutput("midreset_row_out", 64'(row_out), 64'h0);
        applyStimulus(0, 1, 0, 0);
        waitFrameDone(gap);
        checkOutput("post_reset_no_commit_valid", 64'(layout_valid), 64'h0);
        checkOutput("post_reset_no_commit_layout", layout, 64'h0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
